// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared types for the inter-stage pipeline register.
// Occupancy states encode the number of held entries directly.
package pipe_stage_skid_reg_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  function automatic logic [1:0] occ_count(
    input occ_e s
  );
    unique case (s)
      OCC_ONE: occ_count = 2'd1;
      OCC_TWO: occ_count = 2'd2;
      default: occ_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline register with hazard stall/bubble and valid/ready handshake.
// SKID=1 adds a second entry so in_ready_o never depends on out_ready_i.
module pipe_stage_skid_reg
  import pipe_stage_skid_reg_pkg::*;
#(
  parameter int                DATA_W     = 144,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter bit                SKID       = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              bubble_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);

  occ_e              occ_q, occ_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire, out_fire;

  assign out_valid_o = (occ_q != OCC_EMPTY);
  assign out_data_o  = main_q;
  assign count_o     = occ_count(occ_q);

  // A stalled stage ignores downstream ready: nothing pops.
  assign out_fire = out_valid_o & out_ready_i & ~stall_i;
  assign in_fire  = in_valid_i & in_ready_o;

  generate
    if (SKID) begin : g_skid
      assign in_ready_o = ~stall_i & (occ_q != OCC_TWO);

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          skid_q <= BUBBLE_VAL;
        end else begin
          skid_q <= skid_d;
        end
      end
    end else begin : g_noskid
      logic [DATA_W-1:0] unused_skid_d;

      assign in_ready_o    = ~stall_i & (~out_valid_o | out_ready_i);
      assign skid_q        = BUBBLE_VAL;
      assign unused_skid_d = skid_d;
    end
  endgenerate

  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    if (bubble_i) begin
      occ_d  = OCC_EMPTY;
      main_d = BUBBLE_VAL;
      skid_d = BUBBLE_VAL;
    end else if (!stall_i) begin
      unique case (occ_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            main_d = in_data_i;
            occ_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (out_fire) begin
            if (in_fire) begin
              main_d = in_data_i;
            end else begin
              main_d = BUBBLE_VAL;
              occ_d  = OCC_EMPTY;
            end
          end else if (in_fire) begin
            skid_d = in_data_i;
            occ_d  = OCC_TWO;
          end
        end
        OCC_TWO: begin
          if (out_fire) begin
            main_d = skid_q;
            skid_d = BUBBLE_VAL;
            occ_d  = OCC_ONE;
          end
        end
        default: begin
          occ_d  = OCC_EMPTY;
          main_d = BUBBLE_VAL;
          skid_d = BUBBLE_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q  <= OCC_EMPTY;
      main_q <= BUBBLE_VAL;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench: SKID=1 and SKID=0 instances share stimulus; each is
// checked against a bounded-queue model of its handshake rules.
module tb_pipe_stage_skid_reg;

  localparam int          W  = 16;
  localparam logic [W-1:0] BV = 16'h0F0F;

  logic         clk = 1'b0;
  logic         rst = 1'b0, stall = 1'b0, bubble = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  logic         rdy1, ov1, rdy0, ov0;
  logic [W-1:0] od1, od0;
  logic [1:0]   cnt1, cnt0;

  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.DATA_W(W), .BUBBLE_VAL(BV), .SKID(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .bubble_i(bubble),
    .in_valid_i(in_valid), .in_ready_o(rdy1), .in_data_i(in_data),
    .out_valid_o(ov1), .out_ready_i(out_ready), .out_data_o(od1),
    .count_o(cnt1)
  );

  pipe_stage_skid_reg #(.DATA_W(W), .BUBBLE_VAL(BV), .SKID(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .bubble_i(bubble),
    .in_valid_i(in_valid), .in_ready_o(rdy0), .in_data_i(in_data),
    .out_valid_o(ov0), .out_ready_i(out_ready), .out_data_o(od0),
    .count_o(cnt0)
  );

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit st, input bit bb,
                      input bit iv, input bit orr,
                      input logic [W-1:0] d, input bit en = 1'b1);
    bit e1_rdy, e0_rdy;
    @(negedge clk);
    rst = r; stall = st; bubble = bb;
    in_valid = iv; out_ready = orr; in_data = d;
    #1;
    e1_rdy = !st && (q1.size() < 2);
    e0_rdy = !st && ((q0.size() == 0) || orr);
    if (en) begin
      chk("s1.in_ready",  W'(rdy1), W'(e1_rdy));
      chk("s1.out_valid", W'(ov1),  W'(q1.size() > 0));
      chk("s1.out_data",  od1, (q1.size() > 0) ? q1[0] : BV);
      chk("s1.count",     W'(cnt1), W'(q1.size()));
      chk("s0.in_ready",  W'(rdy0), W'(e0_rdy));
      chk("s0.out_valid", W'(ov0),  W'(q0.size() > 0));
      chk("s0.out_data",  od0, (q0.size() > 0) ? q0[0] : BV);
      chk("s0.count",     W'(cnt0), W'(q0.size()));
    end
    if (r || bb) begin
      q1.delete();
      q0.delete();
    end else if (!st) begin
      if (q1.size() > 0 && orr) void'(q1.pop_front());
      if (iv && e1_rdy) q1.push_back(d);
      if (q0.size() > 0 && orr) void'(q0.pop_front());
      if (iv && e0_rdy) q0.push_back(d);
    end
  endtask

  initial begin
    step(1, 0, 0, 0, 0, '0, 1'b0);
    step(0, 0, 0, 0, 0, '0);

    // streaming
    step(0, 0, 0, 1, 1, 16'h0010);
    step(0, 0, 0, 1, 1, 16'h0011);
    step(0, 0, 0, 1, 1, 16'h0012);
    step(0, 0, 0, 0, 1, '0);
    step(0, 0, 0, 0, 1, '0);

    // backpressure, then drain
    step(0, 0, 0, 1, 0, 16'h00A1);
    step(0, 0, 0, 1, 0, 16'h00A2);
    step(0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 1, '0);
    step(0, 0, 0, 0, 1, '0);
    step(0, 0, 0, 0, 1, '0);

    // stall with held data
    step(0, 0, 0, 1, 0, 16'h0055);
    step(0, 1, 0, 1, 1, 16'hBEEF);
    step(0, 1, 0, 1, 1, 16'hBEEF);
    step(0, 1, 0, 1, 1, 16'hBEEF);
    step(0, 0, 0, 1, 1, 16'hBEEF);
    step(0, 0, 0, 0, 1, '0);
    step(0, 0, 0, 0, 1, '0);

    // bubble while full, then bubble together with stall
    step(0, 0, 0, 1, 0, 16'h0B01);
    step(0, 0, 0, 1, 0, 16'h0B02);
    step(0, 0, 1, 1, 0, 16'h0B03);
    step(0, 0, 0, 1, 0, 16'h0C01);
    step(0, 0, 0, 1, 0, 16'h0C02);
    step(0, 1, 1, 1, 0, 16'h0C03);
    step(0, 0, 0, 0, 0, '0);

    // replacement without gap on the single-register variant
    step(0, 0, 0, 1, 0, 16'h0D01);
    step(0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 1, 1, 16'h0D02);
    step(0, 0, 0, 0, 1, '0);
    step(0, 0, 0, 0, 1, '0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 3) != 0),
           W'($urandom));
    end

    // mid-transfer reset
    step(0, 0, 0, 1, 0, 16'h0E01);
    step(1, 0, 0, 1, 0, 16'h0E02);
    step(0, 0, 0, 0, 0, '0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
